// File: rtl/fsk_bit_framer.sv
// fsk_bit_framer: serialises accepted words into preamble+MSB-first bits (clk, reset, s_data/s_valid/s_ready in; bit_out, bit_strobe, busy out)
module fsk_bit_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int SAMPLES_PER_BIT = 100,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  bit_out,
  output logic                  bit_strobe,
  output logic                  busy
);
  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam int NB = PREAMBLE_BITS > DATA_WIDTH ? PREAMBLE_BITS : DATA_WIDTH;
  localparam int IW = $clog2(NB + 1);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] sh, sh_n, sh_l;
  logic bo_n, st_n, bnd, last, pre_last, acc;
  assign bnd = cnt == CW'(SAMPLES_PER_BIT - 1);
  assign last = state == DATA && bnd && idx == IW'(DATA_WIDTH - 1);
  assign pre_last = idx == IW'(PREAMBLE_BITS - 1);
  assign s_ready = state == IDLE || last;
  assign acc = s_valid && s_ready;
  assign busy = state != IDLE;
  assign sh_l = sh << 1;
  always_comb begin
    state_n = state;
    cnt_n = state == IDLE || bnd ? '0 : cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    bo_n = bit_out;
    st_n = 1'b0;
    case (state)
      IDLE: if (acc) begin
        sh_n = s_data;
        idx_n = '0;
        st_n = 1'b1;
        state_n = PREAMBLE_BITS == 0 ? DATA : PREAMBLE;
        bo_n = PREAMBLE_BITS == 0 ? s_data[DATA_WIDTH-1] : 1'b1;
      end
      PREAMBLE: if (bnd) begin
        st_n = 1'b1;
        idx_n = pre_last ? '0 : idx + 1'b1;
        state_n = pre_last ? DATA : PREAMBLE;
        bo_n = pre_last ? sh[DATA_WIDTH-1] : ~bit_out;
      end
      DATA: if (bnd) begin
        st_n = !last || acc;
        state_n = last && !acc ? IDLE : DATA;
        idx_n = last ? '0 : idx + 1'b1;
        sh_n = last ? (acc ? s_data : sh) : sh_l;
        bo_n = last ? acc && s_data[DATA_WIDTH-1] : sh_l[DATA_WIDTH-1];
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      bit_out <= 1'b0;
      bit_strobe <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      bit_out <= bo_n;
      bit_strobe <= st_n;
    end
  end
endmodule

// File: tb/tb_fsk_bit_framer.sv
// tb_fsk_bit_framer: sample-queue model check of two framers (4-bit and no preamble)
module tb_fsk_bit_framer;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] s_data;
  logic s_valid;
  logic s_ready0, bit_out0, bit_strobe0, busy0;
  logic s_ready1, bit_out1, bit_strobe1, busy1;
  int checks = 0;
  int errors = 0;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int busy_c0 = 0, busy_c1 = 0, stb_c0 = 0, stb_c1 = 0;
  logic [31:0] bits0 = '0, bits1 = '0;
  int b0, b1, s0, s1;
  logic r0, r1, idle0, idle1;

  always #5 clk = ~clk;

  fsk_bit_framer #(.DATA_WIDTH(8), .SAMPLES_PER_BIT(4), .PREAMBLE_BITS(4)) dut0 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready0), .bit_out(bit_out0), .bit_strobe(bit_strobe0), .busy(busy0));

  fsk_bit_framer #(.DATA_WIDTH(8), .SAMPLES_PER_BIT(4), .PREAMBLE_BITS(0)) dut1 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready1), .bit_out(bit_out1), .bit_strobe(bit_strobe1), .busy(busy1));

  function automatic logic frame_bit(input int pb, input logic [7:0] w, input int k);
    return k < pb ? ~k[0] : w[7-(k-pb)];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      r0 = q0.size() <= 1;
      idle0 = q0.size() == 0;
      r1 = q1.size() <= 1;
      idle1 = q1.size() == 0;
      if (!idle0) void'(q0.pop_front());
      if (!idle1) void'(q1.pop_front());
      if (s_valid && r0)
        for (int k = idle0 ? 0 : 4; k < 12; k++)
          for (int j = 0; j < 4; j++) q0.push_back({frame_bit(4, s_data, k), j == 0});
      if (s_valid && r1)
        for (int k = 0; k < 8; k++)
          for (int j = 0; j < 4; j++) q1.push_back({frame_bit(0, s_data, k), j == 0});
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("bit_out0", {31'd0, bit_out0}, {31'd0, q0.size() > 0 && q0[0][1]});
    chk("bit_strobe0", {31'd0, bit_strobe0}, {31'd0, q0.size() > 0 && q0[0][0]});
    chk("busy0", {31'd0, busy0}, {31'd0, q0.size() > 0});
    chk("s_ready0", {31'd0, s_ready0}, {31'd0, q0.size() <= 1});
    chk("bit_out1", {31'd0, bit_out1}, {31'd0, q1.size() > 0 && q1[0][1]});
    chk("bit_strobe1", {31'd0, bit_strobe1}, {31'd0, q1.size() > 0 && q1[0][0]});
    chk("busy1", {31'd0, busy1}, {31'd0, q1.size() > 0});
    chk("s_ready1", {31'd0, s_ready1}, {31'd0, q1.size() <= 1});
    busy_c0 += int'(busy0);
    busy_c1 += int'(busy1);
    stb_c0 += int'(bit_strobe0);
    stb_c1 += int'(bit_strobe1);
    if (bit_strobe0) bits0 = {bits0[30:0], bit_out0};
    if (bit_strobe1) bits1 = {bits1[30:0], bit_out1};
    #1;
  endtask

  task automatic mark();
    b0 = busy_c0;
    b1 = busy_c1;
    s0 = stb_c0;
    s1 = stb_c1;
    bits0 = '0;
    bits1 = '0;
  endtask

  task automatic offer(input logic [7:0] w);
    s_data = w;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (q0.size() > 0 || q1.size() > 0 || busy0 || busy1); i++) step();
    chk("idle_timeout", {31'd0, busy0 || busy1}, 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_bit_out", {31'd0, bit_out0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_strobe", {31'd0, bit_strobe0}, 32'd0);
    chk("rst_ready", {31'd0, s_ready0}, 32'd1);
    mark();
    offer(8'hA5);
    wait_idle();
    chk("a5_bits0", {20'd0, bits0[11:0]}, 32'hAA5);
    chk("a5_busy0", busy_c0 - b0, 48);
    chk("a5_strobes0", stb_c0 - s0, 12);
    chk("a5_bits1", {24'd0, bits1[7:0]}, 32'hA5);
    chk("a5_busy1", busy_c1 - b1, 32);
    chk("a5_idle_bit", {31'd0, bit_out0}, 32'd0);
    mark();
    s_data = 8'hFF;
    s_valid = 1'b1;
    step();
    s_data = 8'h00;
    repeat (48) step();
    s_valid = 1'b0;
    wait_idle();
    chk("b2b_bits0", {12'd0, bits0[19:0]}, 32'hAFF00);
    chk("b2b_busy0", busy_c0 - b0, 80);
    chk("b2b_strobes0", stb_c0 - s0, 20);
    chk("b2b_bits1", {16'd0, bits1[15:0]}, 32'hFF00);
    chk("b2b_busy1", busy_c1 - b1, 64);
    offer(8'hA5);
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_bit_out", {31'd0, bit_out0}, 32'd0);
    chk("abort_ready", {31'd0, s_ready0}, 32'd1);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    mark();
    offer(8'h3C);
    wait_idle();
    chk("3c_bits0", {20'd0, bits0[11:0]}, 32'hA3C);
    chk("3c_busy0", busy_c0 - b0, 48);
    mark();
    s_data = 8'h5A;
    s_valid = 1'b1;
    step();
    for (int i = 0; i < 28; i++) begin
      s_data = s_data + 8'h37;
      step();
    end
    s_valid = 1'b0;
    wait_idle();
    chk("toggle_bits0", {20'd0, bits0[11:0]}, 32'hA5A);
    chk("toggle_bits1", {24'd0, bits1[7:0]}, 32'h5A);
    mark();
    offer(8'h80);
    wait_idle();
    chk("80_bits1", {24'd0, bits1[7:0]}, 32'h80);
    chk("80_busy1", busy_c1 - b1, 32);
    chk("80_strobes1", stb_c1 - s1, 8);
    chk("80_bits0", {20'd0, bits0[11:0]}, 32'hA80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
